// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch counter: control-state encoding, BCD digit type and
// display limits.
package stopwatch_pkg;

  localparam logic [1:0] ST_CLEAR = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_STOP  = 2'b10;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned HUND_MAX = 99;
  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;

  typedef enum logic [1:0] {ModeClear, ModeRun, ModeStop} mode_e;

  // The unused 2'b11 encoding behaves as STOP.
  function automatic mode_e decode_mode(logic [1:0] st);
    mode_e m;
    case (st)
      ST_CLEAR: m = ModeClear;
      ST_RUN:   m = ModeRun;
      ST_STOP:  m = ModeStop;
      default:  m = ModeStop;
    endcase
    return m;
  endfunction

  function automatic bcd_digit_t hi_digit(int unsigned lim);
    return bcd_digit_t'(lim / 10);
  endfunction

  function automatic bcd_digit_t lo_digit(int unsigned lim);
    return bcd_digit_t'(lim % 10);
  endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control and display bundle of the stopwatch counter. The lap input exists only when
// LAP_HOLD_EN is defined.
interface stopwatch_counter_if;

  logic [1:0] currentState;
  logic [7:0] hund_bcd;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic       running;
  logic       ovf;
`ifdef LAP_HOLD_EN
  logic       lap;

  modport master (
    output currentState,
    output lap,
    input  hund_bcd,
    input  sec_bcd,
    input  min_bcd,
    input  running,
    input  ovf
  );

  modport slave (
    input  currentState,
    input  lap,
    output hund_bcd,
    output sec_bcd,
    output min_bcd,
    output running,
    output ovf
  );
`else
  modport master (
    output currentState,
    input  hund_bcd,
    input  sec_bcd,
    input  min_bcd,
    input  running,
    input  ovf
  );

  modport slave (
    input  currentState,
    output hund_bcd,
    output sec_bcd,
    output min_bcd,
    output running,
    output ovf
  );
`endif

endinterface

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the time cascade: counts 0..max_digit on enable, wraps and flags carry.
module bcd_digit_counter
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  bcd_digit_t max_digit,
  output bcd_digit_t digit,
  output logic       carry
);

  bcd_digit_t digit_q, digit_d;

  // >= rather than == so a digit can never run past its limit.
  assign carry = en && (digit_q >= max_digit);

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (en) begin
      digit_d = carry ? bcd_digit_t'(0) : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;

endmodule

// File: rtl/stopwatch_counter.sv
// BCD stopwatch (mm:ss.hh) driven by the timer control state. Define LAP_HOLD_EN to add a lap
// input that freezes the displayed value while the count keeps running.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned TICK_HZ = 100
) (
  input logic                c,
  input logic                r,
  stopwatch_counter_if.slave bus
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_div_check
    $error("stopwatch_counter: CLK_HZ/TICK_HZ must be an integer >= 2");
  end

  mode_e         mode;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic          clr;
  logic          running_q, ovf_q;

  assign mode = decode_mode(bus.currentState);
  assign clr  = (mode == ModeClear);

  // The tick wraps the prescaler and advances the time on the same edge.
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    unique case (mode)
      ModeClear: presc_d = '0;
      ModeRun: begin
        if (presc_q == PRESC_LAST) begin
          tick    = 1'b1;
          presc_d = '0;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: presc_d = presc_q;
    endcase
  end

  bcd_digit_t hund_lo, hund_hi, sec_lo, sec_hi, min_lo, min_hi;
  logic       hund_lo_carry, hund_carry, sec_lo_carry, sec_carry, min_lo_carry, min_carry;

  bcd_digit_counter u_hund_lo (
    .clk       (c),
    .rst       (r),
    .clr       (clr),
    .en        (tick),
    .max_digit (lo_digit(HUND_MAX)),
    .digit     (hund_lo),
    .carry     (hund_lo_carry)
  );

  bcd_digit_counter u_hund_hi (
    .clk       (c),
    .rst       (r),
    .clr       (clr),
    .en        (hund_lo_carry),
    .max_digit (hi_digit(HUND_MAX)),
    .digit     (hund_hi),
    .carry     (hund_carry)
  );

  bcd_digit_counter u_sec_lo (
    .clk       (c),
    .rst       (r),
    .clr       (clr),
    .en        (hund_carry),
    .max_digit (lo_digit(SEC_MAX)),
    .digit     (sec_lo),
    .carry     (sec_lo_carry)
  );

  bcd_digit_counter u_sec_hi (
    .clk       (c),
    .rst       (r),
    .clr       (clr),
    .en        (sec_lo_carry),
    .max_digit (hi_digit(SEC_MAX)),
    .digit     (sec_hi),
    .carry     (sec_carry)
  );

  bcd_digit_counter u_min_lo (
    .clk       (c),
    .rst       (r),
    .clr       (clr),
    .en        (sec_carry),
    .max_digit (lo_digit(MIN_MAX)),
    .digit     (min_lo),
    .carry     (min_lo_carry)
  );

  bcd_digit_counter u_min_hi (
    .clk       (c),
    .rst       (r),
    .clr       (clr),
    .en        (min_lo_carry),
    .max_digit (hi_digit(MIN_MAX)),
    .digit     (min_hi),
    .carry     (min_carry)
  );

  always_ff @(posedge c) begin
    if (r) begin
      presc_q   <= '0;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      running_q <= (mode == ModeRun);
      ovf_q     <= min_carry;
    end
  end

  logic [23:0] live;
  logic [23:0] shown;

  assign live = {min_hi, min_lo, sec_hi, sec_lo, hund_hi, hund_lo};

`ifdef LAP_HOLD_EN
  logic        frozen_q, frozen_d;
  logic [23:0] snap_q, snap_d;

  // Capture the value on display when lap is first seen high in RUN.
  always_comb begin
    frozen_d = frozen_q;
    snap_d   = snap_q;
    if (clr) begin
      frozen_d = 1'b0;
      snap_d   = '0;
    end else if (!bus.lap) begin
      frozen_d = 1'b0;
    end else if (!frozen_q && mode == ModeRun) begin
      frozen_d = 1'b1;
      snap_d   = live;
    end
  end

  always_ff @(posedge c) begin
    if (r) begin
      frozen_q <= 1'b0;
      snap_q   <= '0;
    end else begin
      frozen_q <= frozen_d;
      snap_q   <= snap_d;
    end
  end

  assign shown = frozen_q ? snap_q : live;
`else
  assign shown = live;
`endif

  assign bus.hund_bcd = shown[7:0];
  assign bus.sec_bcd  = shown[15:8];
  assign bus.min_bcd  = shown[23:16];
  assign bus.running  = running_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with DIV=4. Seconds/minutes are pre-advanced by forcing
// the internal carry nets so the wrap cases stay within a short run.
module tb_stopwatch_counter;

  logic c = 1'b0;
  logic r = 1'b1;
  int   checks = 0;
  int   failures = 0;

  stopwatch_counter_if bus ();

  stopwatch_counter #(
    .CLK_HZ  (4),
    .TICK_HZ (1)
  ) dut (
    .c   (c),
    .r   (r),
    .bus (bus)
  );

  always #5 c = ~c;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_time(input string tag, input logic [7:0] m, input logic [7:0] s,
                            input logic [7:0] h);
    check_eq({tag, ".min"}, {24'd0, bus.min_bcd}, {24'd0, m});
    check_eq({tag, ".sec"}, {24'd0, bus.sec_bcd}, {24'd0, s});
    check_eq({tag, ".hund"}, {24'd0, bus.hund_bcd}, {24'd0, h});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge c);
    #1;
  endtask

  // Forced seconds carry steps the minutes once per cycle.
  task automatic pump_min(input int n);
    force dut.sec_carry = 1'b1;
    step(n);
    release dut.sec_carry;
  endtask

  task automatic pump_sec(input int n);
    force dut.hund_carry = 1'b1;
    step(n);
    release dut.hund_carry;
  endtask

  task automatic do_clear();
    bus.currentState = 2'b00;
    step(1);
  endtask

  initial begin
    bus.currentState = 2'b01;
`ifdef LAP_HOLD_EN
    bus.lap = 1'b0;
`endif
    // Reset dominates RUN
    r = 1'b1;
    step(2);
    check_time("reset", 8'h00, 8'h00, 8'h00);
    check_eq("reset.running", {31'd0, bus.running}, 32'd0);
    check_eq("reset.ovf", {31'd0, bus.ovf}, 32'd0);

    r = 1'b0;
    step(1);
    check_eq("run.running", {31'd0, bus.running}, 32'd1);
    step(2);
    check_eq("first_tick.pre", {24'd0, bus.hund_bcd}, 32'h00);
    step(1);
    check_eq("first_tick", {24'd0, bus.hund_bcd}, 32'h01);

    // Count 100 ticks from clear, carry through 99
    do_clear();
    check_time("clear", 8'h00, 8'h00, 8'h00);
    check_eq("clear.running", {31'd0, bus.running}, 32'd0);
    bus.currentState = 2'b01;
    step(396);
    check_time("count99", 8'h00, 8'h00, 8'h99);
    step(4);
    check_time("count400", 8'h00, 8'h01, 8'h00);

    // Pause / resume keeps the partial tick
    do_clear();
    bus.currentState = 2'b01;
    step(6);
    check_eq("pause.run6", {24'd0, bus.hund_bcd}, 32'h01);
    bus.currentState = 2'b10;
    step(10);
    check_eq("pause.hold", {24'd0, bus.hund_bcd}, 32'h01);
    check_eq("pause.running", {31'd0, bus.running}, 32'd0);
    bus.currentState = 2'b01;
    step(1);
    check_eq("resume.1", {24'd0, bus.hund_bcd}, 32'h01);
    step(1);
    check_eq("resume.2", {24'd0, bus.hund_bcd}, 32'h02);
    // STOP on the tick cycle suppresses that tick
    step(3);
    bus.currentState = 2'b10;
    step(1);
    check_eq("stop_on_tick", {24'd0, bus.hund_bcd}, 32'h02);
    bus.currentState = 2'b01;
    step(1);
    check_eq("tick_after_stop", {24'd0, bus.hund_bcd}, 32'h03);

    // Full wrap 59:59.99 -> 00:00.00
    do_clear();
    bus.currentState = 2'b10;
    pump_min(59);
    pump_sec(59);
    check_time("preload5959", 8'h59, 8'h59, 8'h00);
    check_eq("preload.ovf", {31'd0, bus.ovf}, 32'd0);
    bus.currentState = 2'b01;
    step(396);
    check_time("wrap.pre", 8'h59, 8'h59, 8'h99);
    check_eq("wrap.pre.ovf", {31'd0, bus.ovf}, 32'd0);
    step(4);
    check_time("wrap", 8'h00, 8'h00, 8'h00);
    check_eq("wrap.ovf", {31'd0, bus.ovf}, 32'd1);
    step(1);
    check_eq("wrap.ovf_pulse", {31'd0, bus.ovf}, 32'd0);
    step(3);
    check_time("wrap.continue", 8'h00, 8'h00, 8'h01);

    // Minutes carry 09:59.99 -> 10:00.00
    do_clear();
    bus.currentState = 2'b10;
    pump_min(9);
    pump_sec(59);
    bus.currentState = 2'b01;
    step(396);
    check_time("min_carry.pre", 8'h09, 8'h59, 8'h99);
    step(4);
    check_time("min_carry", 8'h10, 8'h00, 8'h00);
    check_eq("min_carry.ovf", {31'd0, bus.ovf}, 32'd0);

    // CLEAR mid-count, then state 11 acts as STOP
    do_clear();
    bus.currentState = 2'b10;
    pump_min(12);
    pump_sec(34);
    bus.currentState = 2'b01;
    step(224);
    check_time("at123456", 8'h12, 8'h34, 8'h56);
    bus.currentState = 2'b00;
    step(1);
    check_time("clear_mid", 8'h00, 8'h00, 8'h00);
    bus.currentState = 2'b01;
    step(6);
    bus.currentState = 2'b11;
    step(5);
    check_eq("st11.hold", {24'd0, bus.hund_bcd}, 32'h01);
    check_eq("st11.running", {31'd0, bus.running}, 32'd0);
    bus.currentState = 2'b01;
    step(2);
    check_eq("st11.resume", {24'd0, bus.hund_bcd}, 32'h02);

`ifdef LAP_HOLD_EN
    do_clear();
    bus.currentState = 2'b01;
    step(20);
    check_eq("lap.start", {24'd0, bus.hund_bcd}, 32'h05);
    bus.lap = 1'b1;
    step(1);
    check_time("lap.frozen1", 8'h00, 8'h00, 8'h05);
    step(39);
    check_time("lap.frozen40", 8'h00, 8'h00, 8'h05);
    bus.lap = 1'b0;
    step(1);
    check_time("lap.release", 8'h00, 8'h00, 8'h15);
    // CLEAR drops a held freeze
    bus.lap = 1'b1;
    step(4);
    bus.currentState = 2'b00;
    step(1);
    bus.currentState = 2'b10;
    step(1);
    check_time("lap.clear", 8'h00, 8'h00, 8'h00);
    bus.lap = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
